// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch / execute sequencer.
// Walks FETCH -> DECODE -> EXEC -> (WAIT) -> UPDATE per instruction, owns the
// program counter, the instruction register and the retired-instruction count.
// All outputs are decoded from registers; only imem_addr mirrors pc directly.
module pc_sequencer #(
  parameter logic [9:0] RESET_PC     = 10'h000,
  parameter logic [7:0] IMEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  input  logic        jmp_en,
  input  logic        branch_en,
  input  logic [9:0]  jmp_dir,
  input  logic [5:0]  branch_dir,
  input  logic        wr_busy,
  output logic        exec_en,
  output logic [9:0]  pc,
  output logic        busy,
  output logic        fault,
  output logic [15:0] instr_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_UPDATE = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [7:0]  timer;
  logic [7:0]  timer_next;
  logic [9:0]  pc_q;
  logic [15:0] instr_q;
  logic [15:0] count_q;

  // Control-flow decisions captured in EXEC; the decoder may move on afterwards.
  logic        jmp_q;
  logic        branch_q;
  logic [9:0]  jmp_dir_q;
  logic [5:0]  branch_dir_q;
  logic [9:0]  pc_target;

  // Timeout is declared when this FETCH cycle would be the IMEM_TIMEOUT-th one.
  logic        timeout_hit;
  assign timeout_hit = ({1'b0, timer} + 9'd1) >= {1'b0, IMEM_TIMEOUT};

  // Next-state and fetch-timer logic.
  always_comb begin
    state_next = state;
    timer_next = 8'd0;
    case (state)
      ST_IDLE: begin
        if (run && !halt_req) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_FAULT;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = wr_busy ? ST_WAIT : ST_UPDATE;
      ST_WAIT:   state_next = wr_busy ? ST_WAIT : ST_UPDATE;
      ST_UPDATE: state_next = halt_req ? ST_IDLE : ST_FETCH;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register and fetch timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= 8'd0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Jump beats branch; branch offset is sign-extended and wraps modulo 1024.
  always_comb begin
    pc_target = pc_q + 10'd1;
    if (jmp_q) begin
      pc_target = jmp_dir_q;
    end else if (branch_q) begin
      pc_target = pc_q + {{4{branch_dir_q[5]}}, branch_dir_q};
    end
  end

  // Datapath registers: instruction latch, control capture, pc and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      instr_q      <= 16'h0000;
      count_q      <= 16'h0000;
      jmp_q        <= 1'b0;
      branch_q     <= 1'b0;
      jmp_dir_q    <= 10'h000;
      branch_dir_q <= 6'h00;
    end else begin
      if (state == ST_FETCH && imem_ack) begin
        instr_q <= imem_data;
      end
      if (state == ST_EXEC) begin
        jmp_q        <= jmp_en;
        branch_q     <= branch_en;
        jmp_dir_q    <= jmp_dir;
        branch_dir_q <= branch_dir;
      end
      if (state == ST_UPDATE) begin
        pc_q <= pc_target;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    imem_req    = (state == ST_FETCH);
    exec_en     = (state == ST_EXEC);
    busy        = (state != ST_IDLE) && (state != ST_FAULT);
    fault       = (state == ST_FAULT);
    pc          = pc_q;
    imem_addr   = pc_q;
    instr       = instr_q;
    instr_count = count_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checks of pc_sequencer against a
// per-instruction timeline model (phase offsets from the start of each fetch).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        halt_req;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        jmp_en;
  logic        branch_en;
  logic [9:0]  jmp_dir;
  logic [5:0]  branch_dir;
  logic        wr_busy;
  logic        exec_en;
  logic [9:0]  pc;
  logic        busy;
  logic        fault;
  logic [15:0] instr_count;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .halt_req    (halt_req),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .jmp_en      (jmp_en),
    .branch_en   (branch_en),
    .jmp_dir     (jmp_dir),
    .branch_dir  (branch_dir),
    .wr_busy     (wr_busy),
    .exec_en     (exec_en),
    .pc          (pc),
    .busy        (busy),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [9:0]  pc_exp;
  logic [15:0] cnt_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pc"}, pc, 10'h000);
    chk({tag, ".instr"}, instr, 16'h0000);
    chk({tag, ".imem_req"}, imem_req, 1'b0);
    chk({tag, ".exec_en"}, exec_en, 1'b0);
    chk({tag, ".fault"}, fault, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".count"}, instr_count, 16'h0000);
  endtask

  // IDLE for n cycles; halt_req held high so any run value must be ignored.
  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle.busy", busy, 1'b0);
      chk("idle.imem_req", imem_req, 1'b0);
      chk("idle.exec_en", exec_en, 1'b0);
      chk("idle.pc", pc, pc_exp);
      chk("idle.count", instr_count, cnt_exp);
      run      = 1'($urandom);
      halt_req = 1'b1;
      imem_ack = 1'b0;
      wr_busy  = 1'($urandom);
    end
  endtask

  // From IDLE: request execution; the next cycle is the first FETCH.
  task automatic restart();
    @(negedge clk);
    chk("restart.busy", busy, 1'b0);
    run      = 1'b1;
    halt_req = 1'b0;
    imem_ack = 1'b0;
  endtask

  // One instruction: ack after d stalled FETCH cycles, wr_busy high for wb
  // cycles starting in EXEC. Expected timeline, t = cycles since FETCH start:
  // FETCH t=0..d, DECODE d+1, EXEC d+2, UPDATE d+3+wb, new pc visible after.
  task automatic run_instr(input int d, input int wb, input logic j, input logic [9:0] jd,
                           input logic b, input logic [5:0] bd, input logic h);
    logic [15:0] word;
    int          tu;
    int          npc;
    word = 16'($urandom);
    tu   = d + 3 + wb;
    for (int t = 0; t <= tu; t++) begin
      @(negedge clk);
      chk("imem_req", imem_req, (t <= d));
      if (t <= d) chk("imem_addr", imem_addr, pc_exp);
      chk("exec_en", exec_en, (t == d + 2));
      chk("busy", busy, 1'b1);
      chk("fault", fault, 1'b0);
      chk("pc", pc, pc_exp);
      chk("count", instr_count, cnt_exp);
      if (t > d) chk("instr", instr, word);
      imem_ack  = (t == d);
      imem_data = (t == d) ? word : 16'($urandom);
      if (t == d + 2) begin
        jmp_en = j; branch_en = b; jmp_dir = jd; branch_dir = bd;
      end else begin
        jmp_en = 1'($urandom); branch_en = 1'($urandom);
        jmp_dir = 10'($urandom); branch_dir = 6'($urandom);
      end
      wr_busy  = (t < d + 2) ? 1'($urandom) : (t < d + 2 + wb);
      halt_req = (t == d + 2 || t == tu) ? h : 1'($urandom);
      run      = 1'($urandom);
    end
    if (j) npc = int'(jd);
    else if (b) npc = (int'(pc_exp) + int'($signed(bd)) + 1024) % 1024;
    else npc = (int'(pc_exp) + 1) % 1024;
    pc_exp = 10'(npc);
    if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; wr_busy = 1'b0;
    pc_exp = 10'h000;
    cnt_exp = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_data = 16'h0;
    jmp_en = 1'b0; branch_en = 1'b0; jmp_dir = 10'h0; branch_dir = 6'h0; wr_busy = 1'b0;
    pc_exp = 10'h000;
    cnt_exp = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    idle_hold(4);

    // Straight-line: three instructions, immediate ack, no control flow.
    restart();
    run_instr(0, 0, 1'b0, 10'h0, 1'b0, 6'h0, 1'b0);
    run_instr(0, 0, 1'b0, 10'h0, 1'b0, 6'h0, 1'b0);
    run_instr(0, 0, 1'b0, 10'h0, 1'b0, 6'h0, 1'b1);
    @(negedge clk);
    chk("straight.pc", pc, 10'd3);
    chk("straight.count", instr_count, 16'd3);
    idle_hold(2);

    // Control flow and wrap.
    restart();
    run_instr(0, 0, 1'b1, 10'h155, 1'b0, 6'h00, 1'b0);
    chk("jump.model", pc_exp, 10'h155);
    run_instr(1, 0, 1'b1, 10'h001, 1'b0, 6'h00, 1'b0);
    run_instr(0, 0, 1'b0, 10'h000, 1'b1, 6'b111110, 1'b0);
    run_instr(0, 0, 1'b0, 10'h000, 1'b0, 6'h00, 1'b0);
    run_instr(0, 0, 1'b1, 10'h2A0, 1'b1, 6'd5, 1'b0);
    run_instr(2, 0, 1'b1, 10'h000, 1'b0, 6'h00, 1'b0);
    run_instr(0, 0, 1'b0, 10'h000, 1'b1, 6'h3F, 1'b0);
    // Stall: late ack, store in progress, halt raised in EXEC.
    run_instr(5, 3, 1'b0, 10'h000, 1'b0, 6'h00, 1'b1);
    @(negedge clk);
    chk("halt.busy", busy, 1'b0);
    chk("halt.pc", pc, 10'h000);
    idle_hold(2);

    // Randomized instruction stream.
    restart();
    for (int k = 0; k < 40; k++) begin
      logic h;
      h = ($urandom_range(0, 4) == 0);
      run_instr($urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom), 10'($urandom),
                1'($urandom), 6'($urandom), h);
      if (h) begin
        idle_hold($urandom_range(1, 3));
        restart();
      end
    end
    run_instr(0, 0, 1'b0, 10'h0, 1'b0, 6'h0, 1'b1);
    idle_hold(1);

    // Reset mid-FETCH.
    restart();
    @(negedge clk);
    chk("rf.req", imem_req, 1'b1);
    imem_ack = 1'b0;
    do_reset();
    idle_hold(2);

    // Reset mid-WAIT: no exec_en pulse may follow.
    restart();
    @(negedge clk);
    imem_ack = 1'b1; imem_data = 16'hBEEF;
    @(negedge clk);
    imem_ack = 1'b0; wr_busy = 1'b1;
    @(negedge clk);
    chk("rw.exec_en", exec_en, 1'b1);
    wr_busy = 1'b1;
    @(negedge clk);
    chk("rw.wait_exec", exec_en, 1'b0);
    chk("rw.wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset("rw");
    wr_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rw.after_exec", exec_en, 1'b0);
      chk("rw.after_busy", busy, 1'b0);
    end
    pc_exp = 10'h000;
    cnt_exp = 16'h0000;

    // Fetch timeout: ack never arrives.
    restart();
    for (int t = 0; t < 255; t++) begin
      @(negedge clk);
      chk("to.req", imem_req, 1'b1);
      chk("to.addr", imem_addr, 10'h000);
      chk("to.fault", fault, 1'b0);
      imem_ack = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fault.fault", fault, 1'b1);
      chk("fault.busy", busy, 1'b0);
      chk("fault.req", imem_req, 1'b0);
      chk("fault.exec", exec_en, 1'b0);
      run = 1'b1; halt_req = 1'($urandom); imem_ack = 1'($urandom);
    end
    imem_ack = 1'b0;
    do_reset();
    idle_hold(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
